// File: rtl/instr_fetch_pkg.sv
// ifetch_pkg: shared definitions for the RV32I instruction fetch stage.
//   - pc_src encodings driven by the main controller
//   - fetch FSM state type
//   - reset value of the instruction register (canonical NOP: addi x0,x0,0)
package ifetch_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// pc_next_sel: combinational next-PC multiplexer with misalignment detect.
//   pc         in   current PC
//   pc_src     in   00 PC+4, 01 pc_target, 10 alu_result with bit 0 cleared,
//                   11 (reserved) PC+4
//   pc_target  in   branch/jal target (PC+imm)
//   alu_result in   jalr target
//   next_pc    out  selected next PC (adds wrap modulo 2^XLEN)
//   misaligned out  next_pc is not 4-byte aligned
module pc_next_sel
    import ifetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] plus4;

    assign plus4 = pc + XLEN'(4);

    always_comb begin
        next_pc = plus4;
        case (pc_src)
            PCSRC_TARGET: next_pc = pc_target;
            PCSRC_JALR:   next_pc = alu_result & JALR_MASK;
            default:      next_pc = plus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I instruction fetch stage.
// Holds the PC, issues instruction-memory requests with a ready handshake,
// latches the fetched word and exposes its decode fields. On exec_done the
// next PC is chosen from pc_src; a misaligned target halts the core.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and address (address == pc)
//   imem_rdata/ready    returned instruction word, completion strobe
//   pc_src              next-PC select (see pc_next_sel)
//   pc_target           branch/jal target
//   alu_result          jalr target
//   exec_done           datapath finished the current instruction
//   instr_valid         instr and its fields hold a fetched instruction
//   instr, opc, func3, func7  instruction register and decode fields
//   pc, pc_plus4        address of instr and its successor
//   fetch_err           sticky error (misalignment or timeout); core halted
//
// Build option: define IFETCH_TIMEOUT_EN to enable the fetch watchdog, which
// halts with fetch_err after TIMEOUT_CYCLES consecutive unanswered requests.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int unsigned     TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] alu_result,
    input  logic            exec_done,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opc,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_err
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            err_q;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            timeout;

    pc_next_sel #(
        .XLEN(XLEN)
    ) u_pc_next_sel (
        .pc         (pc_q),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .alu_result (alu_result),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

`ifdef IFETCH_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside FETCH, so every entry into FETCH starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || state != FETCH) begin
            wait_cnt <= '0;
        end else if (!imem_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires during the TIMEOUT_CYCLES-th consecutive unanswered FETCH cycle.
    assign timeout = (state == FETCH) && !imem_ready
                     && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (timeout) begin
                    state_next = HALT;
                end else if (imem_ready) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (exec_done) begin
                    state_next = misaligned ? HALT : FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Outputs: gated by rst so the request drops in the cycle reset is applied
    // and rises in the first cycle after it is released.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH:   imem_req    = !rst;
            HOLD:    instr_valid = !rst;
            default: ;
        endcase
    end

    // PC, instruction register and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            if (state == FETCH && imem_ready) begin
                instr_q <= imem_rdata;
            end
            if (state == HOLD && exec_done) begin
                if (misaligned) begin
                    err_q <= 1'b1;
                end else begin
                    pc_q <= next_pc;
                end
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign instr     = instr_q;
    assign opc       = instr_q[6:0];
    assign func3     = instr_q[14:12];
    assign func7     = instr_q[31:25];
    assign fetch_err = err_q;

endmodule
